// File: rtl/pipelined_adder_nb.sv
// rtl/pipelined_adder_nb.sv - segmented, elastic pipelined ripple-carry adder/subtractor
module pipelined_adder_nb #(
    parameter int WIDTH = 25,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);
    localparam int NSTG = (WIDTH + SEG - 1) / SEG;

    logic             adv;
    logic [WIDTH-1:0] eb;
    logic             ec;

    // The whole pipe moves as one unit: it advances whenever the output slot is free or being drained.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Subtraction is a + ~b + 1, so c_in is overridden when sub is set.
    assign eb = sub ? ~b : b;
    assign ec = sub | c_in;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int LO = k * SEG;
        localparam int SW = (k == NSTG - 1) ? (WIDTH - LO) : SEG;
        localparam int HI = LO + SW;

        logic [SW-1:0] a_seg;
        logic [SW-1:0] b_seg;
        logic          c_i;
        logic          v_i;
        logic [SW:0]   seg;
        logic [HI-1:0] s_nx;

        logic [HI-1:0] s_r;
        logic          c_r;
        logic          v_r;

        if (k == 0) begin : g_head
            assign a_seg = a[SW-1:0];
            assign b_seg = eb[SW-1:0];
            assign c_i   = ec;
            assign v_i   = in_valid;
            assign s_nx  = seg[SW-1:0];
        end else begin : g_body
            // Operand bits for this segment arrive at the bottom of the previous stage's skew register.
            assign a_seg = g_stg[k-1].g_skew.a_r[SW-1:0];
            assign b_seg = g_stg[k-1].g_skew.b_r[SW-1:0];
            assign c_i   = g_stg[k-1].c_r;
            assign v_i   = g_stg[k-1].v_r;
            assign s_nx  = {seg[SW-1:0], g_stg[k-1].s_r};
        end

        assign seg = {1'b0, a_seg} + {1'b0, b_seg} + {{SW{1'b0}}, c_i};

        // Register this segment's partial sum (deskewed low bits included), its carry-out and the valid bit.
        always_ff @(posedge clk) begin
            if (rst) begin
                s_r <= '0;
                c_r <= 1'b0;
                v_r <= 1'b0;
            end else if (adv) begin
                s_r <= s_nx;
                c_r <= seg[SW];
                v_r <= v_i;
            end
        end

        if (k < NSTG - 1) begin : g_skew
            logic [WIDTH-HI-1:0] a_r;
            logic [WIDTH-HI-1:0] b_r;
            logic [WIDTH-HI-1:0] a_nx;
            logic [WIDTH-HI-1:0] b_nx;

            if (k == 0) begin : g_src_port
                assign a_nx = a[WIDTH-1:HI];
                assign b_nx = eb[WIDTH-1:HI];
            end else begin : g_src_prev
                assign a_nx = g_stg[k-1].g_skew.a_r[WIDTH-LO-1:SW];
                assign b_nx = g_stg[k-1].g_skew.b_r[WIDTH-LO-1:SW];
            end

            // Carry the not-yet-added operand bits forward, dropping the segment consumed here.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (adv) begin
                    a_r <= a_nx;
                    b_r <= b_nx;
                end
            end
        end
    end

    assign out_valid = g_stg[NSTG-1].v_r;
    assign sum       = {g_stg[NSTG-1].c_r, g_stg[NSTG-1].s_r};

endmodule

// File: tb/tb_pipelined_adder_nb.sv
// tb/tb_pipelined_adder_nb.sv - scoreboard bench for pipelined_adder_nb in three configurations
module tb_pipelined_adder_nb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // instance 0: WIDTH=25 SEG=8 (NSTG=4)
    logic rst0, iv0, ir0, ci0, sb0, ov0, or0;
    logic [24:0] a0, b0;
    logic [25:0] s0;
    // instance 1: WIDTH=8 SEG=8 (NSTG=1)
    logic rst1, iv1, ir1, ci1, sb1, ov1, or1;
    logic [7:0] a1, b1;
    logic [8:0] s1;
    // instance 2: WIDTH=9 SEG=4 (NSTG=3)
    logic rst2, iv2, ir2, ci2, sb2, ov2, or2;
    logic [8:0] a2, b2;
    logic [9:0] s2;

    pipelined_adder_nb #(.WIDTH(25), .SEG(8)) dut0 (
        .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .c_in(ci0), .sub(sb0), .out_valid(ov0), .out_ready(or0), .sum(s0));
    pipelined_adder_nb #(.WIDTH(8), .SEG(8)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .c_in(ci1), .sub(sb1), .out_valid(ov1), .out_ready(or1), .sum(s1));
    pipelined_adder_nb #(.WIDTH(9), .SEG(4)) dut2 (
        .clk(clk), .rst(rst2), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .c_in(ci2), .sub(sb2), .out_valid(ov2), .out_ready(or2), .sum(s2));

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] q2[$];

    logic ov0_seen, ir0_seen, acc0_seen, ov1_seen, acc1_seen, ov2_seen, acc2_seen;
    logic [25:0] s0_seen;
    logic [8:0]  s1_seen;
    logic [9:0]  s2_seen;

    function automatic logic [63:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input logic sb);
        logic [63:0] m;
        m = 64'd1 << w;
        if (!sb) return x + y + 64'(ci);
        if (x >= y) return m + (x - y);
        return m - (y - x);
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic [24:0] a, input logic [24:0] b,
                          input logic ci, input logic sb, input logic ordy);
        iv0 = v; a0 = a; b0 = b; ci0 = ci; sb0 = sb; or0 = ordy;
        @(negedge clk);
        ov0_seen = ov0; ir0_seen = ir0; s0_seen = s0;
        acc0_seen = iv0 && ir0 && !rst0;
        if (acc0_seen) q0.push_back(model(25, 64'(a), 64'(b), ci, sb));
        @(posedge clk); #1;
    endtask

    task automatic drive1(input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic sb, input logic ordy);
        iv1 = v; a1 = a; b1 = b; ci1 = ci; sb1 = sb; or1 = ordy;
        @(negedge clk);
        ov1_seen = ov1; s1_seen = s1;
        acc1_seen = iv1 && ir1 && !rst1;
        if (acc1_seen) q1.push_back(model(8, 64'(a), 64'(b), ci, sb));
        @(posedge clk); #1;
    endtask

    task automatic drive2(input logic v, input logic [8:0] a, input logic [8:0] b,
                          input logic ci, input logic sb, input logic ordy);
        iv2 = v; a2 = a; b2 = b; ci2 = ci; sb2 = sb; or2 = ordy;
        @(negedge clk);
        ov2_seen = ov2; s2_seen = s2;
        acc2_seen = iv2 && ir2 && !rst2;
        if (acc2_seen) q2.push_back(model(9, 64'(a), 64'(b), ci, sb));
        @(posedge clk); #1;
    endtask

    task automatic drain0();
        int n = 0;
        while (q0.size() != 0 && n < 60) begin drive0(0, '0, '0, 0, 0, 1); n++; end
        check("drain0", 64'(q0.size()), 64'd0);
    endtask

    task automatic drain1();
        int n = 0;
        while (q1.size() != 0 && n < 60) begin drive1(0, '0, '0, 0, 0, 1); n++; end
        check("drain1", 64'(q1.size()), 64'd0);
    endtask

    task automatic drain2();
        int n = 0;
        while (q2.size() != 0 && n < 60) begin drive2(0, '0, '0, 0, 0, 1); n++; end
        check("drain2", 64'(q2.size()), 64'd0);
    endtask

    task automatic regress0();
        int acc = 0;
        int cyc = 0;
        while (acc < 1000 && cyc < 8000) begin
            drive0($urandom_range(0, 3) != 0,
                   ($urandom_range(0, 7) == 0) ? 25'h1FFFFFF : 25'($urandom), 25'($urandom),
                   1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0);
            if (acc0_seen) acc++;
            cyc++;
        end
        check("regress_count0", 64'(acc), 64'd1000);
        drain0();
    endtask

    task automatic regress1();
        int acc = 0;
        int cyc = 0;
        while (acc < 1000 && cyc < 8000) begin
            drive1($urandom_range(0, 3) != 0,
                   ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom), 8'($urandom),
                   1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0);
            if (acc1_seen) acc++;
            cyc++;
        end
        check("regress_count1", 64'(acc), 64'd1000);
        drain1();
    endtask

    task automatic regress2();
        int acc = 0;
        int cyc = 0;
        while (acc < 1000 && cyc < 8000) begin
            drive2($urandom_range(0, 3) != 0,
                   ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom), 9'($urandom),
                   1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0);
            if (acc2_seen) acc++;
            cyc++;
        end
        check("regress_count2", 64'(acc), 64'd1000);
        drain2();
    endtask

    // Monitors: pop on every consumed result, and check that stalled outputs hold.
    logic pend0 = 1'b0, pend1 = 1'b0, pend2 = 1'b0;
    logic [63:0] held0 = '0, held1 = '0, held2 = '0;

    always @(negedge clk) begin
        if (!rst0) begin
            if (pend0) begin
                check("stall_valid0", 64'(ov0), 64'd1);
                check("stall_sum0", 64'(s0), held0);
            end
            if (ov0 && or0) begin
                if (q0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL extra_beat0: got %h expected no result", s0);
                end else check("sb0", 64'(s0), q0.pop_front());
            end
        end
        pend0 <= !rst0 && ov0 && !or0;
        held0 <= 64'(s0);
    end

    always @(negedge clk) begin
        if (!rst1) begin
            if (pend1) begin
                check("stall_valid1", 64'(ov1), 64'd1);
                check("stall_sum1", 64'(s1), held1);
            end
            if (ov1 && or1) begin
                if (q1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL extra_beat1: got %h expected no result", s1);
                end else check("sb1", 64'(s1), q1.pop_front());
            end
        end
        pend1 <= !rst1 && ov1 && !or1;
        held1 <= 64'(s1);
    end

    always @(negedge clk) begin
        if (!rst2) begin
            if (pend2) begin
                check("stall_valid2", 64'(ov2), 64'd1);
                check("stall_sum2", 64'(s2), held2);
            end
            if (ov2 && or2) begin
                if (q2.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL extra_beat2: got %h expected no result", s2);
                end else check("sb2", 64'(s2), q2.pop_front());
            end
        end
        pend2 <= !rst2 && ov2 && !or2;
        held2 <= 64'(s2);
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [13:0] hist;

        rst0 = 1; rst1 = 1; rst2 = 1;
        iv0 = 0; a0 = '0; b0 = '0; ci0 = 0; sb0 = 0; or0 = 0;
        iv1 = 0; a1 = '0; b1 = '0; ci1 = 0; sb1 = 0; or1 = 0;
        iv2 = 0; a2 = '0; b2 = '0; ci2 = 0; sb2 = 0; or2 = 0;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 0; rst1 = 0; rst2 = 0;

        // reset state
        drive0(0, '0, '0, 0, 0, 0);
        check("reset_out_valid", 64'(ov0_seen), 64'd0);
        check("reset_sum", 64'(s0_seen), 64'd0);
        check("reset_in_ready", 64'(ir0_seen), 64'd1);

        // carry through all four segments, latency 4
        drive0(1, 25'h1FFFFFF, 25'd1, 0, 0, 1);
        lat = 0;
        do begin drive0(0, '0, '0, 0, 0, 1); lat++; end while (!ov0_seen && lat < 12);
        check("latency0", 64'(lat), 64'd4);
        check("carry_chain_sum", 64'(s0_seen), 64'h2000000);
        drain0();

        // subtraction, with and without borrow, c_in ignored
        drive0(1, 25'd10, 25'd3, 0, 1, 1);
        drive0(1, 25'd3, 25'd10, 0, 1, 1);
        drive0(1, 25'd10, 25'd3, 1, 1, 1);
        drain0();

        // 8 back-to-back beats: out_valid on cycles 4..11
        hist = '0;
        for (int i = 0; i < 14; i++) begin
            drive0(i < 8, 25'($urandom), 25'($urandom), 1'($urandom), 0, 1);
            hist[i] = ov0_seen;
        end
        check("stream_valid_pattern", 64'(hist), 64'h0FF0);
        drain0();

        // fill, then stall for 3 cycles
        for (int i = 0; i < 6; i++) drive0(1, 25'($urandom), 25'($urandom), 1'($urandom), 1'($urandom), 1);
        for (int i = 0; i < 3; i++) begin
            drive0(1, 25'($urandom), 25'($urandom), 0, 0, 0);
            check("stall_in_ready", 64'(ir0_seen), 64'd0);
        end
        drain0();

        // reset with 3 beats in flight
        for (int i = 0; i < 3; i++) drive0(1, 25'($urandom), 25'($urandom), 0, 0, 1);
        rst0 = 1;
        q0.delete();
        drive0(1, 25'h1234, 25'h1, 0, 0, 1);
        rst0 = 0;
        drive0(0, '0, '0, 0, 0, 0);
        check("rst_mid_out_valid", 64'(ov0_seen), 64'd0);
        check("rst_mid_sum", 64'(s0_seen), 64'd0);
        check("rst_mid_in_ready", 64'(ir0_seen), 64'd1);
        for (int i = 0; i < 6; i++) begin
            drive0(0, '0, '0, 0, 0, 1);
            check("no_stale_beat", 64'(ov0_seen), 64'd0);
        end

        // NSTG=1 and NSTG=3 all-ones + 1
        drive1(1, 8'hFF, 8'h01, 0, 0, 1);
        lat = 0;
        do begin drive1(0, '0, '0, 0, 0, 1); lat++; end while (!ov1_seen && lat < 12);
        check("latency1", 64'(lat), 64'd1);
        check("ones_plus_one1", 64'(s1_seen), 64'h100);
        drain1();

        drive2(1, 9'h1FF, 9'h001, 0, 0, 1);
        lat = 0;
        do begin drive2(0, '0, '0, 0, 0, 1); lat++; end while (!ov2_seen && lat < 12);
        check("latency2", 64'(lat), 64'd3);
        check("ones_plus_one2", 64'(s2_seen), 64'h200);
        drain2();

        // random regression with random backpressure on all configurations
        fork
            regress0();
            regress1();
            regress2();
        join

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
